// File: rtl/conv3x3_sequencer_if.sv
// Address/strobe bus between the 3x3 convolution sequencer and its RAMs/MAC datapath.
// master = sequencer, slave = RAM/MAC/output-buffer side.
interface conv3x3_sequencer_if #(
  parameter int ADDR_W  = 6,
  parameter int OADDR_W = 6
);
  logic [ADDR_W-1:0]  in_addr;
  logic [3:0]         w_addr;
  logic               in_re;
  logic               mac_valid;
  logic               mac_first;
  logic               mac_last;
  logic [OADDR_W-1:0] out_addr;
  logic               out_we;
  logic               out_ready;

  modport master (
    output in_addr, w_addr, in_re, mac_valid, mac_first, mac_last, out_addr, out_we,
    input  out_ready
  );

  modport slave (
    input  in_addr, w_addr, in_re, mac_valid, mac_first, mac_last, out_addr, out_we,
    output out_ready
  );
endinterface

// File: rtl/conv3x3_sequencer.sv
// Sequences one 3x3 valid-convolution pass: 9 tap reads per window, a drain cycle
// for the 1-cycle RAM latency, then a held output write; windows scan row-major.
module conv3x3_sequencer #(
  parameter int IMG_W   = 8,
  parameter int IMG_H   = 8,
  parameter int ADDR_W  = 6,
  parameter int OADDR_W = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  conv3x3_sequencer_if.master  bus
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 3);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 3);
  localparam logic [3:0]    TAP_LAST = 4'd8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_WRITE,
    S_DONE
  } state_t;

  typedef struct packed {
    logic valid;
    logic first;
    logic last;
  } strobe_t;

  state_t        state, nstate;
  logic [RW-1:0] row;
  logic [CW-1:0] col;
  logic [3:0]    tap;
  logic [1:0]    ky, kx;
  logic          win_last;
  strobe_t       stb_d, stb_q;

  logic [ADDR_W-1:0]  iy, ix, win_in_addr;
  logic [OADDR_W-1:0] win_out_addr;

  // Tap index -> kernel offset; a lookup avoids a divider on a 4-bit value.
  always_comb begin
    {ky, kx} = 4'b0000;
    case (tap)
      4'd0:    {ky, kx} = 4'b0000;
      4'd1:    {ky, kx} = 4'b0001;
      4'd2:    {ky, kx} = 4'b0010;
      4'd3:    {ky, kx} = 4'b0100;
      4'd4:    {ky, kx} = 4'b0101;
      4'd5:    {ky, kx} = 4'b0110;
      4'd6:    {ky, kx} = 4'b1000;
      4'd7:    {ky, kx} = 4'b1001;
      4'd8:    {ky, kx} = 4'b1010;
      default: {ky, kx} = 4'b0000;
    endcase
  end

  assign iy           = ADDR_W'(row) + ADDR_W'(ky);
  assign ix           = ADDR_W'(col) + ADDR_W'(kx);
  assign win_in_addr  = iy * ADDR_W'(IMG_W) + ix;
  assign win_out_addr = OADDR_W'(row) * OADDR_W'(IMG_W - 2) + OADDR_W'(col);
  assign win_last     = (row == ROW_LAST) && (col == COL_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= nstate;
  end

  always_comb begin
    nstate       = state;
    busy         = 1'b0;
    done         = 1'b0;
    bus.in_re    = 1'b0;
    bus.in_addr  = '0;
    bus.w_addr   = '0;
    bus.out_we   = 1'b0;
    bus.out_addr = '0;
    case (state)
      S_IDLE: begin
        if (start) nstate = S_ISSUE;
      end
      S_ISSUE: begin
        busy        = 1'b1;
        bus.in_re   = 1'b1;
        bus.in_addr = win_in_addr;
        bus.w_addr  = tap;
        if (tap == TAP_LAST) nstate = S_DRAIN;
      end
      S_DRAIN: begin
        busy   = 1'b1;
        nstate = S_WRITE;
      end
      S_WRITE: begin
        busy         = 1'b1;
        bus.out_we   = 1'b1;
        bus.out_addr = win_out_addr;
        if (bus.out_ready) nstate = win_last ? S_DONE : S_ISSUE;
      end
      S_DONE: begin
        done   = 1'b1;
        nstate = S_IDLE;
      end
      default: nstate = S_IDLE;
    endcase
  end

  // Window position and tap counter; row/col are rebased on every accepted start.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row <= '0;
      col <= '0;
      tap <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            row <= '0;
            col <= '0;
            tap <= '0;
          end
        end
        S_ISSUE: tap <= (tap == TAP_LAST) ? 4'd0 : tap + 4'd1;
        S_WRITE: begin
          if (bus.out_ready) begin
            if (col == COL_LAST) begin
              col <= '0;
              row <= row + 1'b1;
            end else begin
              col <= col + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Strobes trail the address by the RAM read latency so they line up with tap data.
  always_comb begin
    stb_d.valid = (state == S_ISSUE);
    stb_d.first = (state == S_ISSUE) && (tap == 4'd0);
    stb_d.last  = (state == S_ISSUE) && (tap == TAP_LAST);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) stb_q <= '0;
    else      stb_q <= stb_d;
  end

  assign bus.mac_valid = stb_q.valid;
  assign bus.mac_first = stb_q.first;
  assign bus.mac_last  = stb_q.last;

endmodule

// File: doc/conv3x3_sequencer.md
Name: conv3x3_sequencer

Overview:
- Controller that sequences one 3x3 valid-convolution pass over an IMG_W x IMG_H feature map using the shared multiplier and 9-tap accumulator datapath.
- Generates input-buffer and weight-buffer read addresses, the tap-qualified valid/first/last strobes to the multiplier/accumulator, and the output-buffer write handshake.
- Sits between the top-level control (start/done) and the input RAM, weight RAM, MAC datapath and output RAM. All RAMs have 1-cycle synchronous read latency.

Parameters:
- IMG_W, 8, input map width in pixels (>=3)
- IMG_H, 8, input map height in pixels (>=3)
- ADDR_W, 6, input address width; must hold IMG_W*IMG_H-1
- OADDR_W, 6, output address width; must hold (IMG_W-2)*(IMG_H-2)-1

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset
- start  input  1  begin a pass; sampled only in IDLE
- busy  output  1  high from the cycle after start is accepted until done
- done  output  1  one-cycle pulse after the last output write completes
- in_addr  output  ADDR_W  input-map read address
- w_addr  output  4  weight read address, tap index 0..8
- in_re  output  1  read enable to input and weight RAMs
- mac_valid  output  1  tap data is on the multiplier output this cycle
- mac_first  output  1  with mac_valid: tap 0, accumulator loads instead of adds
- mac_last  output  1  with mac_valid: tap 8
- out_addr  output  OADDR_W  output-map write address
- out_we  output  1  write request; held until out_ready
- out_ready  input  1  output buffer accepts the write this cycle

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, row=col=tap=0. All outputs are 0: busy, done, in_re, mac_*, out_we, in_addr, w_addr, out_addr.
- States: IDLE, ISSUE, DRAIN, WRITE, DONE.
- IDLE: start=1 -> ISSUE with row=col=0, tap=0. start is ignored in all other states.
- ISSUE (9 cycles, tap 0..8):
  - in_re=1, w_addr=tap.
  - ky=tap/3, kx=tap%3; in_addr=(row+ky)*IMG_W+(col+kx), computed at full ADDR_W with no truncation for legal parameters.
  - tap=8 -> DRAIN.
- Strobe pipeline: mac_valid, mac_first and mac_last are registered copies of (ISSUE, tap==0, tap==8). They are therefore high exactly 1 cycle after the corresponding address, which covers ISSUE cycles 2..9 and the DRAIN cycle.
- DRAIN (1 cycle): in_re=0. The tap-8 strobes are active. The accumulator register holds the final sum after this edge. -> WRITE.
- WRITE:
  - out_we=1, out_addr=row*(IMG_W-2)+col.
  - Hold out_we and out_addr stable while out_ready=0.
  - On out_ready=1: advance col. At col==IMG_W-3, wrap col to 0 and row++.
  - If the window just written was row==IMG_H-3 and col==IMG_W-3 -> DONE; else -> ISSUE with tap=0.
- DONE (1 cycle): done=1, busy=0 -> IDLE.
- busy=1 in ISSUE, DRAIN and WRITE.
- Latency, start to done: windows*(11+W) + 2 cycles, where W is total out_ready stall cycles. For 8x8 with out_ready tied high: 36*11+2 = 398 cycles.
- Boundaries:
  - out_ready=1 already in the first WRITE cycle gives a zero-stall, 1-cycle WRITE.
  - out_ready is ignored outside WRITE.
  - IMG_W=IMG_H=3 gives a single window with out_addr=0.
  - rst asserted mid-pass aborts immediately to IDLE. No done pulse and no partial write are issued, and a pending out_we drops asynchronously.
  - start held high across DONE begins a new pass on the IDLE cycle that follows.

Test Plan:
- Reset then start=1 for 1 cycle, out_ready=1 (8x8) -> busy rises the next cycle. Window 0 in_addr sequence is 0,1,2,8,9,10,16,17,18, w_addr is 0..8, and done pulses 398 cycles after start.
- Monitor the strobes for window 0 -> mac_first coincides with the first mac_valid, 1 cycle after in_addr=0. mac_last follows 8 cycles later. out_we rises the next cycle with out_addr=0.
- Check window col wrap -> window 6 (row 1, col 0) starts at in_addr=8, and out_addr runs 0..35 exactly once each, in order.
- Hold out_ready=0 for 5 cycles on window 3 -> out_we=1 and out_addr=3 remain stable, no new in_re occurs, and done is delayed by exactly 5 cycles (403).
- Drive rst=0 during the ISSUE of window 10 -> all outputs are 0 asynchronously. After release and a new start, the sequence restarts at in_addr=0, out_addr=0.
- Assert start while busy; separately, use IMG_W=IMG_H=3 -> mid-pass start has no effect. The 3x3 instance issues 9 taps, one write to out_addr=0, and done at cycle 13.
